// File: rtl/stv_pkg.sv
// Shared types and constants for the ST-V input conditioner.
// Coin FSM states, the released-port value, and a small helper.
package stv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    GAP,
    WAIT_REL
  } coin_state_t;

  localparam logic [15:0] STV_IN_IDLE = 16'hFFFF;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/stv_input_cond_if.sv
// Raw-input / conditioned-output bundle of the ST-V input conditioner.
// The master drives the raw pad side, the slave is the conditioner.
interface stv_input_cond_if;

  logic        ce;
  logic [15:0] joy1_raw;
  logic [15:0] joy2_raw;
  logic        coin_btn;
  logic [15:0] joy1;
  logic [15:0] joy2;
  logic        coin1;
  logic        tick;

  modport master (
    output ce, joy1_raw, joy2_raw, coin_btn,
    input  joy1, joy2, coin1, tick
  );

  modport slave (
    input  ce, joy1_raw, joy2_raw, coin_btn,
    output joy1, joy2, coin1, tick
  );

endinterface

// File: rtl/stv_debounce.sv
// Per-bit 2-flop synchroniser followed by a tick-based debouncer.
// A bit flips only after DEB_MS consecutive mismatching ticks.
module stv_debounce #(
  parameter int W      = 33,
  parameter int DEB_MS = 4
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         TICK,
  input  logic [W-1:0] D,
  output logic [W-1:0] Q
);

  localparam int CW = $clog2(DEB_MS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_MS - 1);

  logic [W-1:0]  s1_q;
  logic [W-1:0]  s2_q;
  logic [W-1:0]  st_q;
  logic [W-1:0]  st_d;
  logic [CW-1:0] cnt_q [W];
  logic [CW-1:0] cnt_d [W];

  always_comb begin
    st_d = st_q;
    for (int i = 0; i < W; i++) begin
      cnt_d[i] = cnt_q[i];
      if (s2_q[i] == st_q[i]) begin
        cnt_d[i] = '0;
      end else if (TICK) begin
        if (cnt_q[i] == CNT_LAST) begin
          st_d[i]  = s2_q[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_q <= '0;
      s2_q <= '0;
      st_q <= '0;
      for (int i = 0; i < W; i++) cnt_q[i] <= '0;
    end else begin
      s1_q <= D;
      s2_q <= s1_q;
      st_q <= st_d;
      for (int i = 0; i < W; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign Q = st_q;

endmodule

// File: rtl/stv_input_cond.sv
// ST-V input conditioner: ms tick divider, debounce, coin pulse shaper.
// Outputs are active-low levels for the I/O port block.
module stv_input_cond
  import stv_pkg::*;
#(
  parameter int TICK_DIV    = 53693,
  parameter int DEB_MS      = 4,
  parameter int COIN_MS     = 100,
  parameter int COIN_GAP_MS = 100
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CE,
  input  logic [15:0] JOY1_RAW,
  input  logic [15:0] JOY2_RAW,
  input  logic        COIN_BTN,
  output logic [15:0] JOY1,
  output logic [15:0] JOY2,
  output logic        COIN1,
  output logic        TICK
);

  localparam int DW  = $clog2(TICK_DIV);
  localparam int CCW = $clog2(imax(COIN_MS, COIN_GAP_MS) + 1);
  localparam logic [DW-1:0]  DIV_LAST   = DW'(TICK_DIV - 1);
  localparam logic [CCW-1:0] PULSE_LAST = CCW'(COIN_MS - 1);
  localparam logic [CCW-1:0] GAP_LAST   = CCW'(COIN_GAP_MS - 1);

  logic [DW-1:0]  div_q, div_d;
  logic           tick_q, tick_d;
  logic [32:0]    deb;
  logic           cd;
  coin_state_t    st_q, st_d;
  logic [CCW-1:0] cnt_q, cnt_d;
  logic           coin1_q, coin1_d;
  logic [15:0]    joy1_q, joy1_d;
  logic [15:0]    joy2_q, joy2_d;

  stv_debounce #(
    .W      (33),
    .DEB_MS (DEB_MS)
  ) u_deb (
    .CLK  (CLK),
    .RST  (RST),
    .TICK (tick_q),
    .D    ({COIN_BTN, JOY2_RAW, JOY1_RAW}),
    .Q    (deb)
  );

  assign cd = deb[32];

  always_comb begin
    div_d  = div_q;
    tick_d = 1'b0;
    if (CE) begin
      if (div_q == DIV_LAST) begin
        div_d  = '0;
        tick_d = 1'b1;
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  // A tick coinciding with a transition is not counted in the new state.
  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    unique case (st_q)
      IDLE: begin
        if (cd) begin
          st_d  = PULSE;
          cnt_d = '0;
        end
      end
      PULSE: begin
        if (tick_q) begin
          if (cnt_q == PULSE_LAST) begin
            st_d  = GAP;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      GAP: begin
        if (tick_q) begin
          if (cnt_q == GAP_LAST) begin
            st_d  = cd ? WAIT_REL : IDLE;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      WAIT_REL: begin
        if (!cd) st_d = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end

  always_comb begin
    coin1_d = (st_q != PULSE);
    joy1_d  = ~deb[15:0];
    joy2_d  = ~deb[31:16];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      div_q   <= '0;
      tick_q  <= 1'b0;
      st_q    <= IDLE;
      cnt_q   <= '0;
      coin1_q <= 1'b1;
      joy1_q  <= STV_IN_IDLE;
      joy2_q  <= STV_IN_IDLE;
    end else begin
      div_q   <= div_d;
      tick_q  <= tick_d;
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      coin1_q <= coin1_d;
      joy1_q  <= joy1_d;
      joy2_q  <= joy2_d;
    end
  end

  assign JOY1  = joy1_q;
  assign JOY2  = joy2_q;
  assign COIN1 = coin1_q;
  assign TICK  = tick_q;

endmodule

// File: tb/tb_stv_input_cond.sv
// Bench for stv_input_cond: vector table plus coin/reset sequences.
// Small parameters keep tick, debounce and coin timing short.
module tb_stv_input_cond;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  stv_input_cond_if bus ();

  stv_input_cond #(
    .TICK_DIV    (4),
    .DEB_MS      (2),
    .COIN_MS     (3),
    .COIN_GAP_MS (2)
  ) dut (
    .CLK      (clk),
    .RST      (rst),
    .CE       (bus.ce),
    .JOY1_RAW (bus.joy1_raw),
    .JOY2_RAW (bus.joy2_raw),
    .COIN_BTN (bus.coin_btn),
    .JOY1     (bus.joy1),
    .JOY2     (bus.joy2),
    .COIN1    (bus.coin1),
    .TICK     (bus.tick)
  );

  typedef struct packed {
    logic        rst;
    logic [15:0] j1;
    logic [15:0] j2;
    logic        cn;
    logic [7:0]  n;
    logic [15:0] e1;
    logic [15:0] e2;
    logic        ec;
    logic        tk;
  } vec_t;

  vec_t tbl [11];
  int   n;
  int   falls;
  int   low;
  logic prev;

  task automatic cyc(input int k);
    repeat (k) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input int act,
                         input int lo, input int hi);
    n_vec++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d..%0d", nm, act, lo, hi);
    end
  endtask

  task automatic wait_coin(input logic lvl, input int lim, output int k);
    k = 0;
    do begin
      cyc(1);
      k++;
    end while (bus.coin1 !== lvl && k < lim);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.joy1_raw = '0;
    bus.joy2_raw = '0;
    bus.coin_btn = 1'b0;
    cyc(2);
    rst = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 8'd3,
                16'hFFFF, 16'hFFFF, 1'b1, 1'b1};
    tbl[1]  = '{1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 8'd1,
                16'hFFFF, 16'hFFFF, 1'b1, 1'b1};
    tbl[2]  = '{1'b1, 16'h0000, 16'h0000, 1'b0, 8'd2,
                16'hFFFF, 16'hFFFF, 1'b1, 1'b1};
    tbl[3]  = '{1'b0, 16'h0010, 16'h0000, 1'b0, 8'd14,
                16'hFFEF, 16'hFFFF, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 16'h0010, 16'h0800, 1'b0, 8'd3,
                16'hFFEF, 16'hFFFF, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 16'h0010, 16'h0000, 1'b0, 8'd20,
                16'hFFEF, 16'hFFFF, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 16'hA5A5, 16'h5A5A, 1'b0, 8'd14,
                16'h5A5A, 16'hA5A5, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 16'hFFFF, 16'h0000, 1'b0, 8'd14,
                16'h0000, 16'hFFFF, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 16'h0000, 16'hFFFF, 1'b0, 8'd14,
                16'hFFFF, 16'h0000, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 16'h0000, 16'h0000, 1'b0, 8'd14,
                16'hFFFF, 16'hFFFF, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 16'h0000, 16'h0000, 1'b0, 8'd2,
                16'hFFFF, 16'hFFFF, 1'b1, 1'b1};

    bus.ce = 1'b1;
    rst = 1'b1;
    bus.joy1_raw = '0;
    bus.joy2_raw = '0;
    bus.coin_btn = 1'b0;

    for (int i = 0; i < 11; i++) begin
      rst          = tbl[i].rst;
      bus.joy1_raw = tbl[i].j1;
      bus.joy2_raw = tbl[i].j2;
      bus.coin_btn = tbl[i].cn;
      cyc(int'(tbl[i].n));
      chk($sformatf("v%0d joy1", i), 32'(bus.joy1), 32'(tbl[i].e1));
      chk($sformatf("v%0d joy2", i), 32'(bus.joy2), 32'(tbl[i].e2));
      chk($sformatf("v%0d coin1", i), 32'(bus.coin1), 32'(tbl[i].ec));
      if (tbl[i].tk)
        chk($sformatf("v%0d tick", i), 32'(bus.tick), 32'd0);
    end

    // exact press latency from reset release: 2 sync + 2nd tick + out reg
    do_reset();
    bus.joy1_raw = 16'h0010;
    n = 0;
    do begin
      cyc(1);
      n++;
    end while (bus.joy1 === 16'hFFFF && n < 20);
    chk("press latency", 32'(n), 32'd10);
    chk("press joy1", 32'(bus.joy1), 32'h0000FFEF);
    chk("press joy2", 32'(bus.joy2), 32'h0000FFFF);

    // coin held for 200 clocks gives one pulse
    do_reset();
    bus.coin_btn = 1'b1;
    falls = 0;
    low   = 0;
    prev  = bus.coin1;
    for (int i = 0; i < 200; i++) begin
      cyc(1);
      if (prev && !bus.coin1) falls++;
      if (!bus.coin1) low++;
      prev = bus.coin1;
    end
    chk("held falls", 32'(falls), 32'd1);
    chk_rng("held width", low, 9, 12);
    chk("held level", 32'(bus.coin1), 32'd1);
    chk("held joy1", 32'(bus.joy1), 32'h0000FFFF);
    bus.coin_btn = 1'b0;
    falls = 0;
    prev  = bus.coin1;
    for (int i = 0; i < 30; i++) begin
      cyc(1);
      if (prev && !bus.coin1) falls++;
      prev = bus.coin1;
    end
    chk("release falls", 32'(falls), 32'd0);

    // re-press while a pulse is running is dropped
    do_reset();
    bus.coin_btn = 1'b1;
    wait_coin(1'b0, 30, n);
    chk("rep first fall", 32'(bus.coin1), 32'd0);
    bus.coin_btn = 1'b0;
    cyc(4);
    bus.coin_btn = 1'b1;
    falls = 0;
    prev  = bus.coin1;
    for (int i = 0; i < 40; i++) begin
      cyc(1);
      if (prev && !bus.coin1) falls++;
      prev = bus.coin1;
    end
    chk("rep dropped", 32'(falls), 32'd0);
    chk("rep level", 32'(bus.coin1), 32'd1);
    bus.coin_btn = 1'b0;
    cyc(30);
    bus.coin_btn = 1'b1;
    wait_coin(1'b0, 30, n);
    chk("rep second fall", 32'(bus.coin1), 32'd0);
    wait_coin(1'b1, 20, n);
    chk_rng("rep second width", n, 9, 12);

    // reset in the middle of a pulse, button still held
    do_reset();
    bus.coin_btn = 1'b1;
    wait_coin(1'b0, 30, n);
    chk("mid pulse low", 32'(bus.coin1), 32'd0);
    cyc(3);
    rst = 1'b1;
    cyc(1);
    chk("mid rst coin1", 32'(bus.coin1), 32'd1);
    rst = 1'b0;
    wait_coin(1'b0, 30, n);
    chk("mid rst relatch", 32'(n), 32'd11);
    wait_coin(1'b1, 20, n);
    chk_rng("mid rst width", n, 9, 12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
